// File: rtl/regfile_sb_bank_if.sv
// Register file port bundle: read ports, write ports,
// scoreboard allocation and scoreboard debug view.
interface regfile_sb_bank_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_sb_bank.sv
// Multi-port integer register file with per-register
// scoreboard, optional write bypass and registered read.
module regfile_sb_bank #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int REG_READ = 0,
    parameter int ZERO_REG = 1
) (
    input logic clk,
    input logic reset,
    regfile_sb_bank_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    busy_nxt;
    logic [AW-1:0]       ra [NRD];
    logic [AW-1:0]       wa [NWR];
    logic [XLEN-1:0]     wd [NWR];
    logic [XLEN-1:0]     rv [NRD];
    logic [NRD-1:0]      rh;
    logic [NRD*XLEN-1:0] mux_data;
    logic [NRD-1:0]      rd_busy_c;

    for (genvar i = 0; i < NRD; i++) begin : g_ra
        assign ra[i] = bus.rd_addr[i*AW +: AW];
    end

    for (genvar j = 0; j < NWR; j++) begin : g_wa
        assign wa[j] = bus.wr_addr[j*AW +: AW];
        assign wd[j] = bus.wr_data[j*XLEN +: XLEN];
    end

    // Read mux: array value, optional forward (last port wins), x0 forced to zero
    always_comb begin
        mux_data  = '0;
        rd_busy_c = '0;
        rh        = '0;
        for (int i = 0; i < NRD; i++) begin
            rv[i] = regs[ra[i]];
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && wa[j] == ra[i]) begin
                    rh[i] = 1'b1;
                    if (BYPASS != 0) begin
                        rv[i] = wd[j];
                    end
                end
            end
            if (ZERO_REG != 0 && ra[i] == '0) begin
                rv[i] = '0;
            end
            mux_data[i*XLEN +: XLEN] = rv[i];
            rd_busy_c[i] = busy[ra[i]] && !(BYPASS != 0 && rh[i]);
        end
    end

    // Array update; ascending loop makes the highest port win on collisions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0)) begin
                    regs[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Scoreboard next state: writes clear, a new allocation overrides the clear
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j]) begin
                busy_nxt[wa[j]] = 1'b0;
            end
        end
        if (bus.alloc_en) begin
            busy_nxt[bus.alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    if (REG_READ != 0) begin : g_rreg
        logic [NRD*XLEN-1:0] rd_q;

        // Registered read: capture mux result for presentation next cycle
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= mux_data;
            end
        end

        assign bus.rd_data = rd_q;
    end else begin : g_rcomb
        assign bus.rd_data = mux_data;
    end

    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_sb_bank.sv
// Randomised bench for regfile_sb_bank: three configurations
// compared against an array-based reference model.
module tb_regfile_sb_bank;
    localparam int CFG_NWR [3] = '{2, 1, 1};
    localparam int CFG_BYP [3] = '{1, 0, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_bank_if #(.NWR(2)) ia ();
    regfile_sb_bank_if #(.NWR(1)) ib ();
    regfile_sb_bank_if #(.NWR(1)) ic ();

    regfile_sb_bank #(.NWR(2), .BYPASS(1), .REG_READ(0)) u_a (
        .clk(clk), .reset(reset), .bus(ia)
    );
    regfile_sb_bank #(.NWR(1), .BYPASS(0), .REG_READ(0)) u_b (
        .clk(clk), .reset(reset), .bus(ib)
    );
    regfile_sb_bank #(.NWR(1), .BYPASS(1), .REG_READ(1)) u_c (
        .clk(clk), .reset(reset), .bus(ic)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  ra [2];
    logic        we [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        al_en;
    logic [4:0]  al_a;

    logic [31:0] m_reg  [3][32];
    logic        m_busy [3][32];
    logic [63:0] c_q;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        logic [31:0] v;
        v = m_reg[k][a];
        if (CFG_BYP[k] != 0)
            for (int j = 0; j < CFG_NWR[k]; j++)
                if (we[j] && wa[j] == a) v = wd[j];
        if (a == 0) v = 0;
        return v;
    endfunction

    function automatic logic exp_bz(int k, logic [4:0] a);
        logic h;
        h = 1'b0;
        for (int j = 0; j < CFG_NWR[k]; j++)
            if (we[j] && wa[j] == a) h = 1'b1;
        return m_busy[k][a] && !(CFG_BYP[k] != 0 && h);
    endfunction

    function automatic logic [31:0] exp_bv(int k);
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[k][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
        c_q = '0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; we[i] = 1'b0; wa[i] = '0; wd[i] = '0;
        end
        al_en = 1'b0;
        al_a  = '0;
    endtask

    task automatic drive();
        ia.rd_addr = {ra[1], ra[0]};
        ia.wr_en   = {we[1], we[0]};
        ia.wr_addr = {wa[1], wa[0]};
        ia.wr_data = {wd[1], wd[0]};
        ib.rd_addr = {ra[1], ra[0]};
        ib.wr_en   = we[0];
        ib.wr_addr = wa[0];
        ib.wr_data = wd[0];
        ic.rd_addr = {ra[1], ra[0]};
        ic.wr_en   = we[0];
        ic.wr_addr = wa[0];
        ic.wr_data = wd[0];
        ia.alloc_en = al_en; ia.alloc_addr = al_a;
        ib.alloc_en = al_en; ib.alloc_addr = al_a;
        ic.alloc_en = al_en; ic.alloc_addr = al_a;
    endtask

    task automatic drive_chk();
        drive();
        #2;
        chk("a_rd0", ia.rd_data[31:0], exp_rd(0, ra[0]));
        chk("a_rd1", ia.rd_data[63:32], exp_rd(0, ra[1]));
        chk("a_rb", ia.rd_busy, {exp_bz(0, ra[1]), exp_bz(0, ra[0])});
        chk("a_bv", ia.busy_vec, exp_bv(0));
        chk("b_rd0", ib.rd_data[31:0], exp_rd(1, ra[0]));
        chk("b_rd1", ib.rd_data[63:32], exp_rd(1, ra[1]));
        chk("b_rb", ib.rd_busy, {exp_bz(1, ra[1]), exp_bz(1, ra[0])});
        chk("b_bv", ib.busy_vec, exp_bv(1));
        chk("c_rd", ic.rd_data, c_q);
        chk("c_rb", ic.rd_busy, {exp_bz(2, ra[1]), exp_bz(2, ra[0])});
        chk("c_bv", ic.busy_vec, exp_bv(2));
    endtask

    task automatic tick();
        @(posedge clk);
        c_q = {exp_rd(2, ra[1]), exp_rd(2, ra[0])};
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < CFG_NWR[k]; j++)
                if (we[j] && wa[j] != 0) m_reg[k][wa[j]] = wd[j];
            for (int j = 0; j < CFG_NWR[k]; j++)
                if (we[j]) m_busy[k][wa[j]] = 1'b0;
            if (al_en) m_busy[k][al_a] = 1'b1;
            m_busy[k][0] = 1'b0;
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        model_reset();
        clear_stim();
        drive();
        repeat (2) @(negedge clk);
        chk("rst_a_bv", ia.busy_vec, 0);
        chk("rst_c_rd", ic.rd_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i);
            ra[1] = 5'(31 - i);
            drive_chk();
            tick();
        end

        clear_stim();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5;
        drive_chk();
        chk("byp_a", ia.rd_data[31:0], 32'hDEADBEEF);
        chk("nobyp_b", ib.rd_data[31:0], 32'h0);
        tick();
        clear_stim();
        ra[0] = 5'd5;
        drive_chk();
        chk("next_b", ib.rd_data[31:0], 32'hDEADBEEF);
        chk("rreg_c", ic.rd_data[31:0], 32'hDEADBEEF);
        tick();

        clear_stim();
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234;
        al_en = 1'b1; al_a = 5'd0;
        drive_chk();
        tick();
        clear_stim();
        drive_chk();
        chk("x0_rd", ia.rd_data[31:0], 32'h0);
        chk("x0_bv", ia.busy_vec[0], 1'b0);
        tick();

        clear_stim();
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h11;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h22;
        ra[0] = 5'd7;
        drive_chk();
        chk("coll_byp", ia.rd_data[31:0], 32'h22);
        tick();
        clear_stim();
        ra[0] = 5'd7;
        drive_chk();
        chk("coll_arr", ia.rd_data[31:0], 32'h22);
        tick();

        clear_stim();
        al_en = 1'b1; al_a = 5'd9;
        drive_chk();
        tick();
        clear_stim();
        ra[0] = 5'd9;
        drive_chk();
        chk("sb_set", ia.busy_vec[9], 1'b1);
        chk("sb_rb", ia.rd_busy[0], 1'b1);
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h99;
        drive_chk();
        chk("sb_byp_a", ia.rd_busy[0], 1'b0);
        chk("sb_nobyp_b", ib.rd_busy[0], 1'b1);
        tick();
        drive_chk();
        chk("sb_clr", ia.busy_vec[9], 1'b0);
        al_en = 1'b1; al_a = 5'd9;
        drive_chk();
        tick();
        clear_stim();
        drive_chk();
        chk("sb_setclr", ia.busy_vec[9], 1'b1);
        tick();

        clear_stim();
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hA5A5A5A5;
        drive_chk();
        tick();
        clear_stim();
        ra[0] = 5'd3;
        drive_chk();
        chk("rr_lat0", ic.rd_data[31:0], 32'h0);
        tick();
        drive_chk();
        chk("rr_lat1", ic.rd_data[31:0], 32'hA5A5A5A5);
        tick();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                ra[i] = raddr();
                we[i] = 1'($urandom_range(0, 1));
                wa[i] = raddr();
                wd[i] = $urandom;
            end
            al_en = 1'($urandom_range(0, 1));
            al_a  = raddr();
            drive_chk();
            tick();
        end

        clear_stim();
        ra[0] = 5'd3;
        drive();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mrst_a_bv", ia.busy_vec, 0);
        chk("mrst_b_bv", ib.busy_vec, 0);
        chk("mrst_c_bv", ic.busy_vec, 0);
        chk("mrst_c_rd", ic.rd_data, 0);
        chk("mrst_a_rd", ia.rd_data[31:0], 0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ra[0] = raddr();
            ra[1] = raddr();
            drive_chk();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
